// File: rtl/ff_exc_pkg.sv
// Shared state encoding and the excitation table used by the flip-flop drive sequencer.
package ff_exc_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_DRIVE = ST_DRIVE,
      S_CHECK = ST_CHECK
   } state_e;

   // Returns {d, t, j, k} for a move from q to target; JK don't-cares resolve to 0.
   function automatic logic [3:0] excite(input logic q, input logic tgt);
      return {tgt, q ^ tgt, ~q & tgt, q & ~tgt};
   endfunction

endpackage

// File: rtl/ff_excitation_driver_if.sv
// Target-bit stream handshake between the characterization sequencer and the driver.
interface ff_excitation_driver_if;

   logic tgt_valid;
   logic tgt_bit;
   logic tgt_ready;

   modport master (output tgt_valid, output tgt_bit, input tgt_ready);
   modport slave  (input tgt_valid, input tgt_bit, output tgt_ready);

endinterface

// File: rtl/ff_tgt_fifo.sv
// Small synchronous 1-bit FIFO holding queued target bits; no fall-through, registered ready.
module ff_tgt_fifo #(
   parameter int DEPTH = 4
) (
   input  logic Clk,
   input  logic rst,
   input  logic wr_en_i,
   input  logic wr_data_i,
   input  logic rd_en_i,
   output logic rd_data_o,
   output logic empty_o,
   output logic ready_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [DEPTH-1:0] mem_q;
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic             ready_q;
   logic             pushAcc;
   logic             popAcc;

   assign pushAcc   = wr_en_i & ready_q;
   assign popAcc    = rd_en_i & (count_q != '0);
   assign rd_data_o = mem_q[rdPtr_q];
   assign empty_o   = (count_q == '0);
   assign ready_o   = ready_q;

   always_comb begin
      count_d = count_q;
      case ({pushAcc, popAcc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Ready is registered from the next occupancy, so it never lags a fill or drain.
   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         mem_q   <= '0;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         ready_q <= 1'b0;
      end else begin
         if (pushAcc) begin
            mem_q[wrPtr_q] <= wr_data_i;
            wrPtr_q        <= wrPtr_q + 1'b1;
         end
         if (popAcc) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         count_q <= count_d;
         ready_q <= (count_d != FULL_CNT);
      end
   end

endmodule

// File: rtl/ff_excitation_driver.sv
// Turns a stream of desired next-Q bits into D/T/JK excitation, then checks the returned Q.
module ff_excitation_driver
   import ff_exc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                    Clk,
   input  logic                    rst,
   ff_excitation_driver_if.slave   tgt,
   input  logic                    resync,
   input  logic                    clr_err,
   input  logic                    q_obs,
   output logic                    d_o,
   output logic                    t_o,
   output logic                    j_o,
   output logic                    k_o,
   output logic                    busy,
   output logic                    mismatch,
   output logic                    err_sticky,
   output logic [CNT_W-1:0]        err_cnt
);

   state_e           state_q;
   logic             qModel_q;
   logic             tgt_q;
   logic [3:0]       exc_q;
   logic [CNT_W-1:0] errCnt_q;
   logic [CNT_W-1:0] errCnt_d;
   logic             errSticky_q;
   logic             errSticky_d;
   logic             fifoData;
   logic             fifoEmpty;
   logic             fifoPop;

   ff_tgt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .Clk       (Clk),
      .rst       (rst),
      .wr_en_i   (tgt.tgt_valid),
      .wr_data_i (tgt.tgt_bit),
      .rd_en_i   (fifoPop),
      .rd_data_o (fifoData),
      .empty_o   (fifoEmpty),
      .ready_o   (tgt.tgt_ready)
   );

   assign {d_o, t_o, j_o, k_o} = exc_q;
   assign busy       = (state_q != S_IDLE) || !fifoEmpty;
   assign mismatch   = (state_q == S_CHECK) && (q_obs != tgt_q);
   assign err_sticky = errSticky_q;
   assign err_cnt    = errCnt_q;

   // A pending resync holds the FSM in IDLE, so the pop slips to the following cycle.
   always_comb begin
      fifoPop = 1'b0;
      if (!fifoEmpty) begin
         if (state_q == S_IDLE && !resync) begin
            fifoPop = 1'b1;
         end else if (state_q == S_CHECK) begin
            fifoPop = 1'b1;
         end
      end
   end

   // Clear is applied before the increment so a coincident mismatch still counts once.
   always_comb begin
      errCnt_d    = clr_err ? '0 : errCnt_q;
      errSticky_d = clr_err ? 1'b0 : errSticky_q;
      if (mismatch) begin
         if (errCnt_d != '1) begin
            errCnt_d = errCnt_d + 1'b1;
         end
         errSticky_d = 1'b1;
      end
   end

   // The model tracks the target, not q_obs, so one bad flop does not skew later excitation.
   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         qModel_q    <= 1'b0;
         tgt_q       <= 1'b0;
         exc_q       <= '0;
         errCnt_q    <= '0;
         errSticky_q <= 1'b0;
      end else begin
         errCnt_q    <= errCnt_d;
         errSticky_q <= errSticky_d;
         case (state_q)
            S_IDLE: begin
               if (resync) begin
                  qModel_q <= q_obs;
               end else if (!fifoEmpty) begin
                  tgt_q   <= fifoData;
                  exc_q   <= excite(qModel_q, fifoData);
                  state_q <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               exc_q   <= {tgt_q, 3'b000};
               state_q <= S_CHECK;
            end
            S_CHECK: begin
               qModel_q <= tgt_q;
               if (!fifoEmpty) begin
                  tgt_q   <= fifoData;
                  exc_q   <= excite(tgt_q, fifoData);
                  state_q <= S_DRIVE;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Directed bench: JK flop model under drive, scoreboard of hand-computed excitation per target.
module tb_ff_excitation_driver;
   import ff_exc_pkg::*;

   typedef struct packed {
      logic       tgt;
      logic [3:0] exc;
      logic       mis;
   } exp_t;

   logic       Clk = 1'b0;
   logic       rst;
   logic       resync, clr_err, q_obs;
   logic       d_o, t_o, j_o, k_o, busy, mismatch, err_sticky;
   logic [7:0] err_cnt;
   logic       d2, t2, j2, k2, busy2, mis2, sticky2;
   logic [1:0] errCnt2;
   logic       ffQ, ffSet, stuck0;
   int         testsRun = 0;
   int         testsFailed = 0;
   exp_t       sbQ[$];
   exp_t       cur;
   bit         curValid = 1'b0;
   bit         r2;
   int         acc2;

   ff_excitation_driver_if tgtIf();
   ff_excitation_driver_if tgt2If();

   always #5 Clk = ~Clk;

   ff_excitation_driver #(.DEPTH(4), .CNT_W(8)) dut (
      .Clk(Clk), .rst(rst), .tgt(tgtIf.slave), .resync(resync), .clr_err(clr_err),
      .q_obs(q_obs), .d_o(d_o), .t_o(t_o), .j_o(j_o), .k_o(k_o), .busy(busy),
      .mismatch(mismatch), .err_sticky(err_sticky), .err_cnt(err_cnt)
   );

   // Second instance with a 2-bit counter, fed by a flop stuck at 0.
   ff_excitation_driver #(.DEPTH(4), .CNT_W(2)) dut2 (
      .Clk(Clk), .rst(rst), .tgt(tgt2If.slave), .resync(1'b0), .clr_err(1'b0),
      .q_obs(1'b0), .d_o(d2), .t_o(t2), .j_o(j2), .k_o(k2), .busy(busy2),
      .mismatch(mis2), .err_sticky(sticky2), .err_cnt(errCnt2)
   );

   // JK flop under drive, with hooks to force it to 1 or hold it stuck at 0.
   always_ff @(posedge Clk or posedge rst) begin
      if (rst)          ffQ <= 1'b0;
      else if (ffSet)   ffQ <= 1'b1;
      else if (stuck0)  ffQ <= 1'b0;
      else begin
         case ({j_o, k_o})
            2'b10:   ffQ <= 1'b1;
            2'b01:   ffQ <= 1'b0;
            2'b11:   ffQ <= ~ffQ;
            default: ffQ <= ffQ;
         endcase
      end
   end
   assign q_obs = ffQ;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic b, input logic [3:0] exc, input logic mis, input bit useSb);
      bit accepted = 1'b0;
      tgtIf.tgt_valid = 1'b1;
      tgtIf.tgt_bit   = b;
      for (int n = 0; n < 100 && !accepted; n++) begin
         accepted = tgtIf.tgt_ready;
         @(posedge Clk); #1;
      end
      tgtIf.tgt_valid = 1'b0;
      if (!accepted) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL pushTimeout: got ready=0, expected ready=1 within 100 cycles");
      end else if (useSb) begin
         sbQ.push_back('{tgt: b, exc: exc, mis: mis});
      end
   endtask

   task automatic waitIdle(input string name);
      bit idle = 1'b0;
      for (int n = 0; n < 200 && !idle; n++) begin
         @(negedge Clk);
         idle = !busy;
      end
      if (!idle) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s: got busy=1, expected busy=0 within 200 cycles", name);
      end
   endtask

   // Monitor: pops one expectation per DRIVE cycle, checks mismatch and hold value in CHECK.
   always @(negedge Clk) begin
      if (!rst) begin
         if (dut.state_q == S_DRIVE) begin
            if (sbQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpectedDrive: got drive exc=%0h, expected no drive", {d_o, t_o, j_o, k_o});
               curValid = 1'b0;
            end else begin
               cur = sbQ.pop_front();
               checkOutput("driveExc", {28'd0, d_o, t_o, j_o, k_o}, {28'd0, cur.exc});
               curValid = 1'b1;
            end
         end else if (dut.state_q == S_CHECK && curValid) begin
            checkOutput("checkMismatch", {31'd0, mismatch}, {31'd0, cur.mis});
            checkOutput("holdExc", {28'd0, d_o, t_o, j_o, k_o}, {28'd0, cur.tgt, 3'b000});
            curValid = 1'b0;
         end else if (mismatch) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL spuriousMismatch: got mismatch=1, expected 0");
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 500000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; resync = 1'b0; clr_err = 1'b0; ffSet = 1'b0; stuck0 = 1'b0;
      tgtIf.tgt_valid = 1'b0;  tgtIf.tgt_bit = 1'b0;
      tgt2If.tgt_valid = 1'b0; tgt2If.tgt_bit = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("rstReady", {31'd0, tgtIf.tgt_ready}, 32'd0);
      checkOutput("rstExc", {28'd0, d_o, t_o, j_o, k_o}, 32'd0);
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstErr", {23'd0, err_sticky, err_cnt}, 32'd0);
      rst = 1'b0;
      @(posedge Clk); #1;
      checkOutput("postRstReady", {31'd0, tgtIf.tgt_ready}, 32'd1);

      // Test 1: correct JK flop, targets 1,1,0,0
      applyStimulus(1'b1, 4'b1110, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'b1000, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b0101, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
      waitIdle("t1Idle");
      checkOutput("t1Drained", sbQ.size(), 32'd0);
      checkOutput("t1Err", {23'd0, err_sticky, err_cnt}, 32'd0);

      // Test 2: hold resync so the FIFO fills, then release and drain all five in order
      resync = 1'b1;
      applyStimulus(1'b1, 4'b1110, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b0101, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'b1110, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'b1000, 1'b0, 1'b1);
      tgtIf.tgt_valid = 1'b1;
      tgtIf.tgt_bit   = 1'b0;
      checkOutput("readyFull", {31'd0, tgtIf.tgt_ready}, 32'd0);
      @(posedge Clk); #1;
      checkOutput("readyStillFull", {31'd0, tgtIf.tgt_ready}, 32'd0);
      resync = 1'b0;
      @(posedge Clk); #1;
      checkOutput("readyReassert", {31'd0, tgtIf.tgt_ready}, 32'd1);
      applyStimulus(1'b0, 4'b0101, 1'b0, 1'b1);
      waitIdle("t2Idle");
      checkOutput("t2Drained", sbQ.size(), 32'd0);

      // Test 3: stuck-at-0 flop, three mismatches, then clear coinciding with a fourth
      stuck0 = 1'b1;
      applyStimulus(1'b1, 4'b1110, 1'b1, 1'b1);
      applyStimulus(1'b1, 4'b1000, 1'b1, 1'b1);
      applyStimulus(1'b1, 4'b1000, 1'b1, 1'b1);
      waitIdle("t3Idle");
      checkOutput("t3ErrCnt", {24'd0, err_cnt}, 32'd3);
      checkOutput("t3Sticky", {31'd0, err_sticky}, 32'd1);
      applyStimulus(1'b1, 4'b1000, 1'b1, 1'b1);
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      clr_err = 1'b1;
      @(posedge Clk); #1;
      clr_err = 1'b0;
      checkOutput("t3ClrErrCnt", {24'd0, err_cnt}, 32'd1);
      checkOutput("t3ClrSticky", {31'd0, err_sticky}, 32'd1);
      waitIdle("t3bIdle");
      stuck0 = 1'b0;

      // Test 4 (first half): force Q=1, resync in IDLE with a queued 0
      ffSet = 1'b1;
      @(posedge Clk); #1;
      ffSet = 1'b0;
      tgtIf.tgt_valid = 1'b1;
      tgtIf.tgt_bit   = 1'b0;
      resync = 1'b1;
      @(posedge Clk); #1;
      tgtIf.tgt_valid = 1'b0;
      sbQ.push_back('{tgt: 1'b0, exc: 4'b0101, mis: 1'b0});
      @(posedge Clk); #1;
      checkOutput("popDelayedK", {31'd0, k_o}, 32'd0);
      checkOutput("popDelayedBusy", {31'd0, busy}, 32'd1);
      resync = 1'b0;
      @(posedge Clk); #1;
      checkOutput("resyncJKT", {29'd0, j_o, k_o, t_o}, 32'b011);
      waitIdle("t5Idle");
      checkOutput("t5Drained", sbQ.size(), 32'd0);
      checkOutput("t5ErrHold", {24'd0, err_cnt}, 32'd1);

      // Test 6: reset during DRIVE with two targets still queued
      resync = 1'b1;
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
      resync = 1'b0;
      @(posedge Clk); #1;
      checkOutput("preRstExc", {28'd0, d_o, t_o, j_o, k_o}, 32'b1110);
      rst = 1'b1;
      #1;
      checkOutput("midRstExc", {28'd0, d_o, t_o, j_o, k_o}, 32'd0);
      checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
      checkOutput("midRstReady", {31'd0, tgtIf.tgt_ready}, 32'd0);
      checkOutput("midRstErr", {23'd0, err_sticky, err_cnt}, 32'd0);
      @(posedge Clk); #1;
      rst = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge Clk);
         checkOutput("postRstQuiet", {30'd0, mismatch, busy}, 32'd0);
      end
      checkOutput("postRstReady2", {31'd0, tgtIf.tgt_ready}, 32'd1);

      // CNT_W=2 instance: five mismatches saturate at 3
      acc2 = 0;
      tgt2If.tgt_valid = 1'b1;
      tgt2If.tgt_bit   = 1'b1;
      for (int n = 0; n < 100 && acc2 < 5; n++) begin
         r2 = tgt2If.tgt_ready;
         @(posedge Clk); #1;
         if (r2) acc2++;
      end
      tgt2If.tgt_valid = 1'b0;
      checkOutput("dut2Accepted", acc2, 32'd5);
      for (int n = 0; n < 200 && busy2; n++) begin
         @(negedge Clk);
      end
      checkOutput("dut2Idle", {31'd0, busy2}, 32'd0);
      checkOutput("dut2ErrSat", {30'd0, errCnt2}, 32'd3);
      checkOutput("dut2Sticky", {31'd0, sticky2}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
